// File: rtl/jtcps_pkg.sv
// Shared definitions for the CPS DTACK generator: state encoding, counter
// width and the max-of-selected-waits helper.
package jtcps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_BUSY = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int TCNT_W = 8;

  // Largest wait count among the selected channels. Wait counts are packed
  // ww bits per channel; up to 8 channels are supported.
  function automatic logic [TCNT_W-1:0] max_wait(
    input logic [63:0] waits,
    input logic [7:0]  sel,
    input int          ch,
    input int          ww
  );
    logic [TCNT_W-1:0] m;
    logic [63:0]       mask;
    logic [63:0]       w;
    m    = {TCNT_W{1'b0}};
    mask = (64'd1 << ww) - 64'd1;
    for (int n = 0; n < 8; n++) begin
      w = (waits >> (n * ww)) & mask;
      if (n < ch && sel[n] && (w[TCNT_W-1:0] > m)) begin
        m = w[TCNT_W-1:0];
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/jtcps_dtack_gen_wmax.sv
// Combinational wait-count selector: maximum programmed wait over the
// selected channels, or the default wait when nothing is selected.
module jtcps_dtack_wmax
  import jtcps_pkg::*;
#(
  parameter int              CH    = 4,
  parameter int              WW    = 2,
  parameter logic [CH*WW-1:0] WAITS = {(CH*WW){1'b0}},
  parameter int              WDEF  = 1
) (
  input  logic [CH-1:0]     sel,
  output logic [TCNT_W-1:0] wmax
);

  logic [63:0] waits_s;
  logic [7:0]  sel_s;

  // Pick the default wait for unmapped accesses, otherwise the channel maximum
  always_comb begin
    waits_s = 64'(WAITS);
    sel_s   = 8'(sel);
    if (sel == {CH{1'b0}}) begin
      wmax = TCNT_W'(WDEF);
    end else begin
      wmax = max_wait(waits_s, sel_s, CH, WW);
    end
  end

endmodule

// File: rtl/jtcps_dtack_gen.sv
// 68000 DTACKn generator for CPS main CPU buses.
// Optional feature macro: JTCPS_DTACK_TOUT_EN (bus error on stuck accesses).
// Each bus cycle latches the channel selects, burns the channel wait count,
// then needs the selected ready flags high on two consecutive cen samples.
module jtcps_dtack_gen
  import jtcps_pkg::*;
#(
  parameter int               CH    = 4,
  parameter int               WW    = 2,
  parameter logic [CH*WW-1:0] WAITS = {(CH*WW){1'b0}},
  parameter int               WDEF  = 1,
  parameter int               TOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          cenb,
  input  logic          ASn,
  input  logic          UDSn,
  input  logic          LDSn,
  input  logic          BGACKn,
  input  logic [CH-1:0] cs,
  input  logic [CH-1:0] ok,
  output logic          DTACKn,
  output logic          BERRn,
  output logic [7:0]    wait_cnt
);

  localparam logic [TCNT_W-1:0] TOUT_L = TCNT_W'(TOUT);

  state_t            state_r;
  logic [CH-1:0]     sel_r;
  logic [TCNT_W-1:0] wcnt_r;
  logic [TCNT_W-1:0] tcnt_r;
  logic              ok1_r;
  logic              dtackn_r;
  logic              berrn_r;
  logic [7:0]        wait_cnt_r;

  logic [TCNT_W-1:0] wmax_s;
  logic [TCNT_W-1:0] tcnt_inc_s;
  logic              rdy_s;
  logic              start_s;
  logic              unused_s;

  jtcps_dtack_wmax #(
    .CH    (CH),
    .WW    (WW),
    .WAITS (WAITS),
    .WDEF  (WDEF)
  ) u_wmax (
    .sel  (cs),
    .wmax (wmax_s)
  );

  // Cycle start qualification, readiness of the latched channels, saturating tcnt
  always_comb begin
    start_s    = ~ASn & (~UDSn | ~LDSn) & BGACKn;
    rdy_s      = &(ok | ~sel_r);
    tcnt_inc_s = (tcnt_r == {TCNT_W{1'b1}}) ? tcnt_r : tcnt_r + {{(TCNT_W-1){1'b0}}, 1'b1};
  end

  // Falling-phase enable and the timeout limit are not needed in every build
  assign unused_s = ^{1'b0, cenb, TOUT_L};

  // Bus-cycle state machine; ASn high ends any cycle on the very next clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sel_r      <= {CH{1'b0}};
      wcnt_r     <= {TCNT_W{1'b0}};
      tcnt_r     <= {TCNT_W{1'b0}};
      ok1_r      <= 1'b0;
      dtackn_r   <= 1'b1;
      berrn_r    <= 1'b1;
      wait_cnt_r <= 8'd0;
    end else if (state_r != ST_IDLE && ASn) begin
      state_r    <= ST_IDLE;
      ok1_r      <= 1'b0;
      dtackn_r   <= 1'b1;
      berrn_r    <= 1'b1;
      wait_cnt_r <= tcnt_r;
    end else if (cen) begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            sel_r   <= cs;
            wcnt_r  <= wmax_s;
            tcnt_r  <= {{(TCNT_W-1){1'b0}}, 1'b1};
            ok1_r   <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          tcnt_r <= tcnt_inc_s;
          if (wcnt_r == {TCNT_W{1'b0}}) begin
            // the cen that leaves WAIT already takes the first ready sample
            state_r <= ST_BUSY;
            ok1_r   <= rdy_s;
          end else begin
            wcnt_r <= wcnt_r - {{(TCNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_BUSY: begin
          tcnt_r <= tcnt_inc_s;
`ifdef JTCPS_DTACK_TOUT_EN
          if (tcnt_r >= TOUT_L) begin
            state_r <= ST_ERR;
            berrn_r <= 1'b0;
          end else if (rdy_s && ok1_r) begin
            state_r  <= ST_ACK;
            dtackn_r <= 1'b0;
          end else begin
            ok1_r <= rdy_s;
          end
`else
          if (rdy_s && ok1_r) begin
            state_r  <= ST_ACK;
            dtackn_r <= 1'b0;
          end else begin
            ok1_r <= rdy_s;
          end
`endif
        end
        ST_ACK: begin
          state_r <= ST_ACK;
        end
`ifdef JTCPS_DTACK_TOUT_EN
        ST_ERR: begin
          state_r <= ST_ERR;
        end
`endif
        default: begin
          state_r  <= ST_IDLE;
          dtackn_r <= 1'b1;
          berrn_r  <= 1'b1;
        end
      endcase
    end
  end

  assign DTACKn   = dtackn_r;
  assign BERRn    = berrn_r;
  assign wait_cnt = wait_cnt_r;

endmodule
